// File: rtl/axis_packetizer_pkg.sv
// -----------------------------------------------------------------------------
// axis_packetizer_pkg
// Shared constants and helpers for the AXI-Stream packetizer.
//   DEF_DATA_W      default sample / tdata width
//   DEF_FIFO_DEPTH  default buffer depth in words
//   DROP_MAX        saturation value of the overflow counter
//   cnt_w()         width of an occupancy count for a given depth
// -----------------------------------------------------------------------------
package axis_packetizer_pkg;

  localparam int          DEF_DATA_W     = 64;
  localparam int          DEF_FIFO_DEPTH = 512;
  localparam logic [31:0] DROP_MAX       = 32'hFFFF_FFFF;

  // An occupancy count must represent 0..depth inclusive, so it is one bit
  // wider than the read/write pointers.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo
// Single-clock first-word-fall-through buffer. The head word is always visible
// on rdata while empty is low. Count, full and empty are registered and move
// on the same edge as the push/pop that changes them.
//   clk, reset   clock, asynchronous active-high reset
//   clear        synchronous flush, wins over push/pop
//   push, wdata  write request and data (ignored while full)
//   pop          read request (ignored while empty)
//   rdata        head word
//   count        words held
//   full, empty  registered occupancy flags
// -----------------------------------------------------------------------------
module axis_pkt_fifo
  import axis_packetizer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rdata,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam int             CW       = cnt_w(FIFO_DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [CW-1:0]     count_nxt;

  always_comb begin
    do_push   = push & ~full & ~clear;
    do_pop    = pop & ~empty & ~clear;
    count_nxt = count;
    if (clear)
      count_nxt = '0;
    else if (do_push & ~do_pop)
      count_nxt = count + CW'(1);
    else if (do_pop & ~do_push)
      count_nxt = count - CW'(1);
  end

  // Flags are derived from the next count so they are registered yet never
  // lag the count by a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; its content is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/axis_packetizer.sv
// -----------------------------------------------------------------------------
// axis_packetizer
// Captures samples from a free-running (no backpressure) source into a FWFT
// buffer and replays them as an AXI4-Stream master, asserting TLAST on the
// last beat of every packet of programmable length.
//
// Optional build macro AXIS_PACKETIZER_TEST_PATTERN_EN adds input src_sel;
// with src_sel=1 every enabled cycle writes an internal incrementing counter
// instead of s_data.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   src_sel               (macro only) 1 = test-pattern source
//   enable                capture enable
//   clear                 synchronous flush: buffer, beat count, drop count
//   packet_size[31:0]     beats per packet (0 and 1 mean one beat)
//   s_data, s_valid       sample input
//   m_axis_t*             AXI4-Stream master (tkeep is all ones)
//   fill_level            words buffered
//   full, empty           buffer flags
//   drop_count[31:0]      samples lost to overflow, saturating
// -----------------------------------------------------------------------------
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef AXIS_PACKETIZER_TEST_PATTERN_EN
  input  logic                          src_sel,
`endif
  input  logic                          enable,
  input  logic                          clear,
  input  logic [31:0]                   packet_size,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [DATA_W/8-1:0]           m_axis_tkeep,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          full,
  output logic                          empty,
  output logic [31:0]                   drop_count
);

  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              push;
  logic              drop;
  logic              xfer;
  logic              is_last;
  logic [31:0]       beat_cnt;
  logic [31:0]       pkt_len;
  logic [31:0]       pkt_len_in;

`ifdef AXIS_PACKETIZER_TEST_PATTERN_EN
  logic [DATA_W-1:0] pat_cnt;

  assign wr_req  = enable & (src_sel | s_valid);
  assign wr_data = src_sel ? pat_cnt : s_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pat_cnt <= '0;
    else if (clear)
      pat_cnt <= '0;
    else if (push & src_sel)
      pat_cnt <= pat_cnt + DATA_W'(1);
  end
`else
  assign wr_req  = enable & s_valid;
  assign wr_data = s_data;
`endif

  // A write against a full buffer is lost even if a pop frees a slot on the
  // same edge; clear suppresses both outcomes.
  assign push = wr_req & ~full & ~clear;
  assign drop = wr_req & full & ~clear;

  axis_pkt_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .wdata (wr_data),
    .pop   (xfer),
    .rdata (m_axis_tdata),
    .count (fill_level),
    .full  (full),
    .empty (empty)
  );

  assign m_axis_tvalid = ~empty;
  assign m_axis_tkeep  = '1;
  assign xfer          = m_axis_tvalid & m_axis_tready & ~clear;
  assign pkt_len_in    = (packet_size == 32'd0) ? 32'd1 : packet_size;
  assign is_last       = (beat_cnt == pkt_len - 32'd1);
  assign m_axis_tlast  = m_axis_tvalid & is_last;

  // pkt_len only reloads while idle between packets or on the TLAST beat, so
  // a register write mid-packet cannot move TLAST under a stalled master.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt   <= 32'd0;
      pkt_len    <= 32'd1;
      drop_count <= 32'd0;
    end else begin
      if (clear)
        beat_cnt <= 32'd0;
      else if (xfer)
        beat_cnt <= is_last ? 32'd0 : beat_cnt + 32'd1;

      if (((beat_cnt == 32'd0) && !m_axis_tvalid) || (xfer && is_last))
        pkt_len <= pkt_len_in;

      if (clear)
        drop_count <= 32'd0;
      else if (drop && (drop_count != DROP_MAX))
        drop_count <= drop_count + 32'd1;
    end
  end

endmodule

// File: doc/axis_packetizer.md
# axis_packetizer

Parametrised AXI-Stream packetizer: captures samples from a free-running source into an internal buffer and emits them on an AXI4-Stream master. It asserts TLAST on the final accepted beat of every packet of programmable length. It replaces the fixed 64-bit sample path in the custom PL block feeding the DMA FIFO, adding configurable width and depth, overflow accounting, synchronous flush, and tready-correct TLAST generation. Control inputs come from the system-bus register file in the parent block.

## Interface
- DATA_W, 64, sample and tdata width; multiple of 8
- FIFO_DEPTH, 512, buffer depth in words; power of two, ≥ 4
- `clk`  in  1  single clock for all logic
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  capture enable
- `clear`  in  1  synchronous flush pulse
- `packet_size`  in  32  beats per packet; 0 and 1 both mean one beat
- `s_data`  in  DATA_W  sample; no backpressure
- `s_valid`  in  1  sample strobe
- `m_axis_tdata`  out  DATA_W  output data
- `m_axis_tvalid`  out  1  output valid
- `m_axis_tready`  in  1  downstream ready
- `m_axis_tlast`  out  1  last beat of packet
- `m_axis_tkeep`  out  DATA_W/8  constant all-ones
- `fill_level`  out  $clog2(FIFO_DEPTH)+1  words buffered
- `full`, `empty`  out  1  buffer flags
- `drop_count`  out  32  samples lost to overflow; saturating

## Operation
- Write: `s_valid & enable & ~full` pushes `s_data`. A write with `s_valid & enable & full` is a drop: `drop_count` increments and saturates at 0xFFFF_FFFF.
- The `full` flag is registered. A write is dropped even if a read occurs in the same cycle. There is no write-through of a pop.
- Read side is first-word-fall-through: `m_axis_tvalid = ~empty`, and head data is presented on `m_axis_tdata`. A beat transfers on `tvalid & tready`, which pops the head.
- `beat_cnt` (32 b) counts transferred beats within the current packet. It resets to 0 after the TLAST beat.
- `pkt_len` register holds max(`packet_size`,1). It loads from `packet_size` when either condition holds:
  - on any cycle with `beat_cnt==0` and `tvalid==0`;
  - on the TLAST transfer cycle.
- `pkt_len` is held otherwise, so TLAST stays stable while the master stalls.
- `m_axis_tlast = tvalid & (beat_cnt == pkt_len-1)`.
- `clear`:
  - empties the buffer and zeroes `beat_cnt` and `drop_count`;
  - takes priority over a write or read in the same cycle;
  - leaves any partially sent packet truncated with no TLAST;
  - the next beat starts a new packet.
- With `enable` low, no writes or drops occur. Draining continues.

## Timing
- Reset values:
  - `tvalid`=0, `tlast`=0, `empty`=1, `full`=0;
  - `fill_level`=0, `drop_count`=0, `beat_cnt`=0, `pkt_len`=1;
  - `tdata` is don't-care.
- Latency: a sample written at edge N appears with `tvalid`=1 after edge N. Minimum one cycle from input to output.
- Throughput: one write and one read per cycle. Simultaneous push and pop leaves `fill_level` unchanged.
- `fill_level`, `full` (count==FIFO_DEPTH) and `empty` (count==0) are registered and updated at the same edge as the push or pop.
- Pointers wrap modulo FIFO_DEPTH. The count is one bit wider than the pointers.
- The outputs obey the AXI rule that `tdata` and `tlast` are stable while `tvalid & ~tready`.

## Configuration
- `AXIS_PACKETIZER_TEST_PATTERN_EN` defined:
  - adds input `src_sel` (1 b);
  - when `src_sel`=1, `s_valid` and `s_data` are ignored. Every cycle with `enable` high is a write attempt, and the written value is an internal DATA_W counter.
  - The counter increments only on a successful push. It is reset to 0 by `reset` and `clear`.
  - Drops count the same way as in normal mode.
- Undefined: `src_sel` and the counter are absent. Data always comes from `s_data`.

## Structure
- Package `axis_packetizer_pkg` holds:
  - the default DATA_W and FIFO_DEPTH constants;
  - the DROP_MAX (32'hFFFF_FFFF) constant;
  - a helper function for the count width.
- Sub-module `axis_pkt_fifo` is a single-clock FWFT buffer with registered full/empty/count and an async reset. Clear, drop accounting and TLAST logic live in the top module.

## Test plan
- Setup: DATA_W=64, FIFO_DEPTH=8, `packet_size`=4, `tready`=1. Stimulus: 8 samples 0..7. Required: TLAST on beats 3 and 7 only, `drop_count`=0.
- `tready`=0 with 10 samples written. Required: `full`=1 after the 8th sample, `drop_count`=2, `fill_level`=8. Releasing `tready` outputs samples 0..7 in order.
- `packet_size`=0. Required: every beat has TLAST. Changing `packet_size` from 4 to 2 after beat 1 still gives TLAST on beat 3, then every 2nd beat.
- Random `tready` toggling during a packet. Required: `tdata` and `tlast` never change while `tvalid & ~tready`.
- `clear` pulsed after 2 of 4 beats, with a simultaneous write. Required: `empty`=1, `drop_count`=0, and the next packet's 4th beat carries TLAST.
- Macro defined, `src_sel`=1, `enable` held for 5 cycles. Required: output data 0,1,2,3,4. An async `reset` mid-packet drops `tvalid` and `tlast` immediately.
